// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file.
// Holds default widths, the hardwired-zero register index and the register
// word type.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // x0 always reads zero and silently drops writes
  localparam int ZERO_REG = 0;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port of the register file.
// Selects a register by address, forces x0 and reset to read zero, and, when
// REGFILE_BYPASS_EN is defined, forwards same-cycle write data on an address
// match.
// Ports:
//   reset      - active-high reset; forces data to zero while asserted
//   regs       - flattened register storage from the top
//   addr       - read address
//   reg_write  - write enable of the write port (bypass build only)
//   rd_addr    - write address (bypass build only)
//   write_data - write data (bypass build only)
//   data       - read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                    reset,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                   addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                                    reg_write,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  input  logic [DATA_WIDTH-1:0]                   write_data,
`endif
  output logic [DATA_WIDTH-1:0]                   data
);

  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // x0 is excluded here implicitly by the zero override below
    if (reg_write && (rd_addr == addr)) begin
      data = write_data;
    end
`endif
    if (reset || (addr == ADDR_WIDTH'(ZERO_REG))) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// General-purpose integer register file: two asynchronous read ports and one
// synchronous write port, x0 hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding
// of same-cycle write data to matching read ports.
// Ports:
//   clk        - system clock, writes on rising edge
//   reset      - asynchronous active-high reset, clears all registers
//   reg_write  - write enable
//   rs1_addr   - read port 1 address
//   rs2_addr   - read port 2 address
//   rd_addr    - write address
//   write_data - write data
//   rs1_data   - read port 1 data
//   rs2_data   - read port 2 data
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (reg_write && (rd_addr != ADDR_WIDTH'(ZERO_REG))) begin
      regs[rd_addr] <= write_data;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rs1 (
    .reset      (reset),
    .regs       (regs),
    .addr       (rs1_addr),
`ifdef REGFILE_BYPASS_EN
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .write_data (write_data),
`endif
    .data       (rs1_data)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rs2 (
    .reset      (reset),
    .regs       (regs),
    .addr       (rs2_addr),
`ifdef REGFILE_BYPASS_EN
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .write_data (write_data),
`endif
    .data       (rs2_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  import regfile_pkg::*;

  logic       clk;
  logic       reset;
  logic       reg_write;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;
  word_t      write_data;
  word_t      rs1_data;
  word_t      rs2_data;

  int vectors;
  int errors;

  register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t observed, input word_t expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // advance past the next rising edge, leaving inputs stable away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    rs1_addr   = '0;
    rs2_addr   = '0;
    rd_addr    = '0;
    write_data = '0;

    // reset held 2 cycles; a write attempted during reset must be lost
    rd_addr    = 5'd7;
    write_data = 32'hDEADBEEF;
    reg_write  = 1'b1;
    rs1_addr   = 5'd7;
    rs2_addr   = 5'd7;
    tick();
    tick();
    chk("reset_rs1", rs1_data, 32'h00000000);
    chk("reset_rs2", rs2_data, 32'h00000000);
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    chk("write_during_reset_lost", rs1_data, 32'h00000000);

    // x1 = A5A5A5A5
    rd_addr = 5'd1; write_data = 32'hA5A5A5A5; reg_write = 1'b1;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd1;
    #1;
    chk("x1_write", rs1_data, 32'hA5A5A5A5);

    // x2 = 5A5A5A5A, read both ports simultaneously
    rd_addr = 5'd2; write_data = 32'h5A5A5A5A; reg_write = 1'b1;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    chk("dual_rs1_x1", rs1_data, 32'hA5A5A5A5);
    chk("dual_rs2_x2", rs2_data, 32'h5A5A5A5A);

    // write to x0 discarded, and x0 never forwarded in the same cycle
    rd_addr = 5'd0; write_data = 32'hFFFFFFFF; reg_write = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0_same_cycle", rs1_data, 32'h00000000);
    tick();
    reg_write = 1'b0;
    #1;
    chk("x0_rs1", rs1_data, 32'h00000000);
    chk("x0_rs2", rs2_data, 32'h00000000);

    // reg_write low: no write to x3
    rd_addr = 5'd3; write_data = 32'hAAAAAAAA; reg_write = 1'b0;
    tick();
    rs1_addr = 5'd3;
    #1;
    chk("x3_no_write", rs1_data, 32'h00000000);

    // back-to-back writes x3, x4, x5
    reg_write = 1'b1;
    rd_addr = 5'd3; write_data = 32'h33333333;
    tick();
    rd_addr = 5'd4; write_data = 32'h44444444;
    tick();
    rd_addr = 5'd5; write_data = 32'h55555555;
    tick();
    reg_write = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    chk("b2b_x3", rs1_data, 32'h33333333);
    chk("b2b_x4", rs2_data, 32'h44444444);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    chk("same_addr_rs1_x5", rs1_data, 32'h55555555);
    chk("same_addr_rs2_x5", rs2_data, 32'h55555555);
    rs1_addr = 5'd2; rs2_addr = 5'd1;
    #1;
    chk("x2_retained", rs1_data, 32'h5A5A5A5A);
    chk("x1_retained", rs2_data, 32'hA5A5A5A5);

    // read/write collision on empty x6
    rd_addr = 5'd6; write_data = 32'h12345678; reg_write = 1'b1;
    rs1_addr = 5'd6; rs2_addr = 5'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("collide_x6_pre_edge", rs1_data, 32'h12345678);
`else
    chk("collide_x6_pre_edge", rs1_data, 32'h00000000);
`endif
    chk("collide_other_port", rs2_data, 32'hA5A5A5A5);
    tick();
    reg_write = 1'b0;
    #1;
    chk("collide_x6_post_edge", rs1_data, 32'h12345678);

    // collision overwriting a live register, seen on port 2
    rd_addr = 5'd1; write_data = 32'h0F0F0F0F; reg_write = 1'b1;
    rs1_addr = 5'd2; rs2_addr = 5'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("collide_x1_pre_edge", rs2_data, 32'h0F0F0F0F);
`else
    chk("collide_x1_pre_edge", rs2_data, 32'hA5A5A5A5);
`endif
    chk("collide_unrelated", rs1_data, 32'h5A5A5A5A);
    tick();
    reg_write = 1'b0;
    #1;
    chk("collide_x1_post_edge", rs2_data, 32'h0F0F0F0F);

    // asynchronous reset mid-cycle, with a write pending that must be lost
    @(posedge clk);
    #3;
    rd_addr = 5'd5; write_data = 32'hCAFEF00D; reg_write = 1'b1;
    rs1_addr = 5'd1; rs2_addr = 5'd5;
    reset = 1'b1;
    #1;
    chk("async_reset_rs1", rs1_data, 32'h00000000);
    chk("async_reset_rs2", rs2_data, 32'h00000000);
    #9;
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    chk("post_reset_x1", rs1_data, 32'h00000000);
    chk("post_reset_x2", rs2_data, 32'h00000000);
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    chk("post_reset_x5", rs1_data, 32'h00000000);
    chk("post_reset_x6", rs2_data, 32'h00000000);

    // register file still writable after reset
    rd_addr = 5'd31; write_data = 32'h80000001; reg_write = 1'b1;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd31;
    #1;
    chk("x31_write", rs1_data, 32'h80000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
